// File: rtl/mem_system_pp.sv
// Ping-pong memory subsystem: A/B data banks plus weight and const banks,
// a handshaked bank swap that drains core reads, and a counted DMA burst
// writer that wins over core writes when both hit the same bank.

// One read port's output side: registers the bank word on accept and
// optionally adds an output stage. Data holds while no read completes.
module mem_system_pp_rd #(
    parameter int DATA_W = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fire,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    logic [RD_LAT:1]   vld_pipe_d, vld_pipe_q;
    logic [DATA_W-1:0] s1_data_d, s1_data_q;

    // shift accept markers down the pipe; capture the bank word on accept
    always_comb begin
        vld_pipe_d = RD_LAT'({vld_pipe_q, fire});
        s1_data_d  = fire ? mem_rdata : s1_data_q;
    end

    // first read stage and valid shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            s1_data_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_data_q  <= s1_data_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data_d, s2_data_q;
            // output stage refreshes only when a read leaves stage 1
            always_comb s2_data_d = vld_pipe_q[1] ? s1_data_q : s2_data_q;
            // output register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) s2_data_q <= '0;
                else        s2_data_q <= s2_data_d;
            end
            assign rd_data = s2_data_q;
        end else begin : g_lat1
            assign rd_data = s1_data_q;
        end
    endgenerate

    assign rd_valid = vld_pipe_q[RD_LAT];
endmodule

module mem_system_pp #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32768,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              bank_sel,
    input  logic              core_rd_en,
    output logic              core_rd_ready,
    input  logic [ADDR_W-1:0] core_rd_addr,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_rd_valid,
    input  logic              core_wr_en,
    output logic              core_wr_ready,
    input  logic [ADDR_W-1:0] core_wr_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic              weight_rd_en,
    input  logic              const_rd_en,
    input  logic [ADDR_W-1:0] weight_rd_addr,
    input  logic [ADDR_W-1:0] const_rd_addr,
    output logic [DATA_W-1:0] weight_rd_data,
    output logic [DATA_W-1:0] const_rd_data,
    output logic              weight_rd_valid,
    output logic              const_rd_valid,
    input  logic              dma_start,
    input  logic [1:0]        dma_target,
    input  logic [ADDR_W-1:0] dma_base_addr,
    input  logic [ADDR_W:0]   dma_len,
    input  logic              dma_wvalid,
    output logic              dma_wready,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              err_dma_start
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] TGT_A = 2'd0, TGT_B = 2'd1, TGT_W = 2'd2, TGT_C = 2'd3;

    typedef enum logic [1:0] {SW_IDLE, SW_PEND, SW_SWAP} sw_state_t;
    typedef enum logic       {DMA_IDLE, DMA_BURST}       dma_state_t;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] mem_w [DEPTH];
    logic [DATA_W-1:0] mem_c [DEPTH];

    sw_state_t   sw_state_d, sw_state_q;
    dma_state_t  dma_state_d, dma_state_q;
    logic        bank_sel_d, bank_sel_q;
    logic        rd_inflight_d, rd_inflight_q;
    logic [1:0]  tgt_d, tgt_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [ADDR_W:0]   rem_d, rem_q;
    logic        done_d, done_q, err_d, err_q;
    logic        dma_beat, core_rd_fire, core_wr_fire;
    logic [1:0]  wr_bank_tgt;

    assign dma_busy     = (dma_state_q == DMA_BURST);
    assign dma_wready   = dma_busy;
    assign dma_beat     = dma_busy && dma_wvalid;
    assign dma_done     = done_q;
    assign err_dma_start = err_q;
    assign bank_sel     = bank_sel_q;
    // core writes go to the bank the core is not reading
    assign wr_bank_tgt  = bank_sel_q ? TGT_A : TGT_B;
    assign core_wr_ready = (sw_state_q == SW_IDLE) && !(dma_beat && tgt_q == wr_bank_tgt);
    assign core_rd_fire = core_rd_en && core_rd_ready;
    assign core_wr_fire = core_wr_en && core_wr_ready;

    // swap FSM: block the core, wait for reads still short of the output, toggle
    always_comb begin
        sw_state_d    = sw_state_q;
        bank_sel_d    = bank_sel_q;
        swap_ack      = 1'b0;
        core_rd_ready = 1'b1;
        rd_inflight_d = (RD_LAT == 2) ? core_rd_fire : 1'b0;
        case (sw_state_q)
            SW_IDLE: if (swap_req) sw_state_d = SW_PEND;
            SW_PEND: begin
                core_rd_ready = 1'b0;
                if (!rd_inflight_q) sw_state_d = SW_SWAP;
            end
            SW_SWAP: begin
                swap_ack   = 1'b1;
                bank_sel_d = !bank_sel_q;
                sw_state_d = SW_IDLE;
            end
            default: sw_state_d = SW_IDLE;
        endcase
    end

    // DMA FSM: latch burst on start, walk a wrapping address per beat
    always_comb begin
        dma_state_d = dma_state_q;
        tgt_d       = tgt_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (dma_state_q)
            DMA_IDLE: if (dma_start) begin
                tgt_d  = dma_target;
                addr_d = dma_base_addr;
                rem_d  = dma_len;
                if (dma_len == '0) done_d = 1'b1;
                else               dma_state_d = DMA_BURST;
            end
            DMA_BURST: begin
                if (dma_start) err_d = 1'b1;
                if (dma_wvalid) begin
                    addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        done_d      = 1'b1;
                        dma_state_d = DMA_IDLE;
                    end
                end
            end
            default: dma_state_d = DMA_IDLE;
        endcase
    end

    // control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_state_q    <= SW_IDLE;
            bank_sel_q    <= 1'b0;
            rd_inflight_q <= 1'b0;
            dma_state_q   <= DMA_IDLE;
            tgt_q         <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            sw_state_q    <= sw_state_d;
            bank_sel_q    <= bank_sel_d;
            rd_inflight_q <= rd_inflight_d;
            dma_state_q   <= dma_state_d;
            tgt_q         <= tgt_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // bank writes; the ready logic keeps DMA and core off the same bank
    always_ff @(posedge clk) begin
        if (dma_beat && tgt_q == TGT_A)          mem_a[addr_q[IDX_W-1:0]] <= dma_wdata;
        else if (core_wr_fire && bank_sel_q)     mem_a[core_wr_addr[IDX_W-1:0]] <= core_wr_data;
        if (dma_beat && tgt_q == TGT_B)          mem_b[addr_q[IDX_W-1:0]] <= dma_wdata;
        else if (core_wr_fire && !bank_sel_q)    mem_b[core_wr_addr[IDX_W-1:0]] <= core_wr_data;
        if (dma_beat && tgt_q == TGT_W)          mem_w[addr_q[IDX_W-1:0]] <= dma_wdata;
        if (dma_beat && tgt_q == TGT_C)          mem_c[addr_q[IDX_W-1:0]] <= dma_wdata;
    end

    mem_system_pp_rd #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_core_rd (
        .clk(clk), .reset(reset), .fire(core_rd_fire),
        .mem_rdata(bank_sel_q ? mem_b[core_rd_addr[IDX_W-1:0]] : mem_a[core_rd_addr[IDX_W-1:0]]),
        .rd_data(core_rd_data), .rd_valid(core_rd_valid));

    mem_system_pp_rd #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_weight_rd (
        .clk(clk), .reset(reset), .fire(weight_rd_en),
        .mem_rdata(mem_w[weight_rd_addr[IDX_W-1:0]]),
        .rd_data(weight_rd_data), .rd_valid(weight_rd_valid));

    mem_system_pp_rd #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_const_rd (
        .clk(clk), .reset(reset), .fire(const_rd_en),
        .mem_rdata(mem_c[const_rd_addr[IDX_W-1:0]]),
        .rd_data(const_rd_data), .rd_valid(const_rd_valid));
endmodule

// File: tb/tb_mem_system_pp.sv
// Directed bench for mem_system_pp: DMA bursts, reads, swap, conflicts, reset.
module tb_mem_system_pp;
    localparam int DW = 32, AW = 6, DEPTH = 64;

    logic clk = 1'b0, reset = 1'b0;
    logic swap_req = 0, swap_ack, bank_sel;
    logic core_rd_en = 0, core_rd_ready, core_rd_valid;
    logic [AW-1:0] core_rd_addr = '0;
    logic [DW-1:0] core_rd_data;
    logic core_wr_en = 0, core_wr_ready;
    logic [AW-1:0] core_wr_addr = '0;
    logic [DW-1:0] core_wr_data = '0;
    logic weight_rd_en = 0, const_rd_en = 0, weight_rd_valid, const_rd_valid;
    logic [AW-1:0] weight_rd_addr = '0, const_rd_addr = '0;
    logic [DW-1:0] weight_rd_data, const_rd_data;
    logic dma_start = 0, dma_wvalid = 0, dma_wready, dma_busy, dma_done, err_dma_start;
    logic [1:0] dma_target = '0;
    logic [AW-1:0] dma_base_addr = '0;
    logic [AW:0] dma_len = '0;
    logic [DW-1:0] dma_wdata = '0;

    int n_vec = 0, n_err = 0;
    logic exp_bs = 1'b0;

    always #5 clk = ~clk;

    mem_system_pp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .swap_req(swap_req), .swap_ack(swap_ack), .bank_sel(bank_sel),
        .core_rd_en(core_rd_en), .core_rd_ready(core_rd_ready), .core_rd_addr(core_rd_addr),
        .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid),
        .core_wr_en(core_wr_en), .core_wr_ready(core_wr_ready), .core_wr_addr(core_wr_addr),
        .core_wr_data(core_wr_data),
        .weight_rd_en(weight_rd_en), .const_rd_en(const_rd_en),
        .weight_rd_addr(weight_rd_addr), .const_rd_addr(const_rd_addr),
        .weight_rd_data(weight_rd_data), .const_rd_data(const_rd_data),
        .weight_rd_valid(weight_rd_valid), .const_rd_valid(const_rd_valid),
        .dma_start(dma_start), .dma_target(dma_target), .dma_base_addr(dma_base_addr),
        .dma_len(dma_len), .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
        .dma_wdata(dma_wdata), .dma_busy(dma_busy), .dma_done(dma_done),
        .err_dma_start(err_dma_start));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // all tasks start and end at a falling edge
    task automatic rd(input int port, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        logic v;
        logic [DW-1:0] d;
        case (port)
            0: begin core_rd_en = 1; core_rd_addr = a; #1 chk("core_rd_ready", core_rd_ready, 1); end
            1: begin weight_rd_en = 1; weight_rd_addr = a; end
            default: begin const_rd_en = 1; const_rd_addr = a; end
        endcase
        @(negedge clk);
        core_rd_en = 0; weight_rd_en = 0; const_rd_en = 0;
        v = (port == 0) ? core_rd_valid : (port == 1) ? weight_rd_valid : const_rd_valid;
        d = (port == 0) ? core_rd_data  : (port == 1) ? weight_rd_data  : const_rd_data;
        chk($sformatf("rd_valid p%0d @%0h", port, a), v, 1);
        chk($sformatf("rd_data p%0d @%0h", port, a), d, exp);
        @(negedge clk);
        v = (port == 0) ? core_rd_valid : (port == 1) ? weight_rd_valid : const_rd_valid;
        d = (port == 0) ? core_rd_data  : (port == 1) ? weight_rd_data  : const_rd_data;
        chk("rd_valid_drop", v, 0);
        chk("rd_data_hold", d, exp);
    endtask

    task automatic dma_run(input logic [1:0] tgt, input logic [AW-1:0] base, input int len,
                           input logic [DW-1:0] d0, input int poke_at);
        logic exp_wr;
        exp_wr = !(tgt == (exp_bs ? 2'd0 : 2'd1));
        dma_start = 1; dma_target = tgt; dma_base_addr = base; dma_len = len[AW:0];
        @(negedge clk);
        dma_start = 0;
        for (int i = 0; i < len; i++) begin
            dma_wvalid = 1; dma_wdata = d0 + DW'(i);
            dma_start = (i == poke_at);
            if (i == poke_at) begin dma_base_addr = '0; dma_len = 1; end
            #1;
            chk("dma_wready", dma_wready, 1);
            chk("dma_busy", dma_busy, 1);
            chk("core_wr_ready_burst", core_wr_ready, exp_wr);
            @(negedge clk);
            dma_start = 0;
        end
        dma_wvalid = 0;
        chk("dma_done", dma_done, 1);
        chk("dma_busy_end", dma_busy, 0);
        @(negedge clk);
        chk("dma_done_pulse", dma_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst bank_sel", bank_sel, 0);
        chk("rst swap_ack", swap_ack, 0);
        chk("rst dma_busy", dma_busy, 0);
        chk("rst dma_done", dma_done, 0);
        chk("rst err", err_dma_start, 0);
        chk("rst core_rd_valid", core_rd_valid, 0);
        chk("rst core_rd_data", core_rd_data, 0);
        chk("rst weight_rd_data", weight_rd_data, 0);
        chk("rst const_rd_valid", const_rd_valid, 0);
        reset = 1;
        @(negedge clk);

        // burst into A, read back through bank_sel=0
        dma_run(2'd0, 6'h10, 4, 32'd1, -1);
        rd(0, 6'h10, 32'd1);
        rd(0, 6'h13, 32'd4);

        // DMA beat to write bank B collides with core write
        dma_start = 1; dma_target = 2'd1; dma_base_addr = 6'h20; dma_len = 1;
        @(negedge clk);
        dma_start = 0; dma_wvalid = 1; dma_wdata = 32'hB0;
        core_wr_en = 1; core_wr_addr = 6'h21; core_wr_data = 32'hC1;
        #1 chk("wr_conflict_ready", core_wr_ready, 0);
        @(negedge clk);
        dma_wvalid = 0;
        #1 chk("wr_retry_ready", core_wr_ready, 1);
        chk("conflict dma_done", dma_done, 1);
        @(negedge clk);
        core_wr_en = 0;

        // back-to-back reads then swap
        core_rd_en = 1; core_rd_addr = 6'h10;
        @(negedge clk);
        core_rd_addr = 6'h11;
        chk("b2b d0", core_rd_data, 32'd1);
        @(negedge clk);
        core_rd_addr = 6'h12; swap_req = 1;
        chk("b2b d1", core_rd_data, 32'd2);
        @(negedge clk);
        swap_req = 0; core_rd_addr = 6'h13;
        #1 chk("pend rd_ready", core_rd_ready, 0);
        chk("pend wr_ready", core_wr_ready, 0);
        chk("inflight from A", core_rd_data, 32'd3);
        chk("inflight valid", core_rd_valid, 1);
        @(negedge clk);
        core_rd_en = 0;
        chk("swap_ack", swap_ack, 1);
        chk("pend read blocked", core_rd_valid, 0);
        chk("bank_sel pre", bank_sel, 0);
        @(negedge clk);
        chk("swap_ack drop", swap_ack, 0);
        chk("bank_sel post", bank_sel, 1);
        exp_bs = 1;
        rd(0, 6'h20, 32'hB0);
        rd(0, 6'h21, 32'hC1);

        // core write now lands in A
        core_wr_en = 1; core_wr_addr = 6'h30; core_wr_data = 32'hA30;
        #1 chk("wr A ready", core_wr_ready, 1);
        @(negedge clk);
        core_wr_en = 0;

        // DMA into the read bank while the core reads the same word: old data
        dma_start = 1; dma_target = 2'd1; dma_base_addr = 6'h20; dma_len = 1;
        @(negedge clk);
        dma_start = 0; dma_wvalid = 1; dma_wdata = 32'hB1;
        core_rd_en = 1; core_rd_addr = 6'h20;
        #1 chk("rd bank dma wr_ready", core_wr_ready, 1);
        @(negedge clk);
        dma_wvalid = 0; core_rd_en = 0;
        chk("rdw old data", core_rd_data, 32'hB0);
        @(negedge clk);
        rd(0, 6'h20, 32'hB1);

        // weight burst wrapping past DEPTH-1, const burst
        dma_run(2'd2, 6'(DEPTH - 2), 4, 32'h100, -1);
        rd(1, 6'd62, 32'h100);
        rd(1, 6'd63, 32'h101);
        rd(1, 6'd0,  32'h102);
        rd(1, 6'd1,  32'h103);
        dma_run(2'd3, 6'd5, 1, 32'h55, -1);
        rd(2, 6'd5, 32'h55);

        // zero-length burst, then start while busy
        dma_run(2'd3, 6'd5, 0, 32'hDEAD, -1);
        rd(2, 6'd5, 32'h55);
        chk("err before", err_dma_start, 0);
        dma_run(2'd3, 6'd8, 3, 32'h80, 1);
        chk("err sticky", err_dma_start, 1);
        rd(2, 6'd8,  32'h80);
        rd(2, 6'd10, 32'h82);
        chk("err still", err_dma_start, 1);

        // reset mid-burst
        dma_start = 1; dma_target = 2'd0; dma_base_addr = 6'h38; dma_len = 4;
        @(negedge clk);
        dma_start = 0; dma_wvalid = 1; dma_wdata = 32'h50;
        @(negedge clk);
        dma_wdata = 32'h51;
        @(negedge clk);
        dma_wvalid = 0; reset = 0;
        #1 chk("mid rst busy", dma_busy, 0);
        chk("mid rst done", dma_done, 0);
        chk("mid rst bank_sel", bank_sel, 0);
        chk("mid rst err", err_dma_start, 0);
        @(negedge clk);
        reset = 1; exp_bs = 0;
        @(negedge clk);
        chk("post rst no done", dma_done, 0);
        chk("post rst busy", dma_busy, 0);
        dma_run(2'd0, 6'h38, 2, 32'h60, -1);
        rd(0, 6'h38, 32'h60);
        rd(0, 6'h39, 32'h61);
        rd(0, 6'h30, 32'hA30);
        rd(0, 6'h11, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
